mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch side and data load/store side.
- Sits between the pipeline top's I-bus (IAD/IDT/ACKI_n) and D-bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n) and a single memory/MMIO port.
- Data side has priority, with a bounded-starvation rule for fetch.
- A watchdog terminates accesses the memory never acknowledges and flags a bus error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting; the next grant goes to I.
- TIMEOUT, 255, cycles in BUSY without m_ack_n low before the access is aborted (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held until i_ack_n low.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word; valid while i_ack_n low.
- i_ack_n  out  1  fetch done, active-low, one-cycle pulse.
- d_req  in  1  data request; held until d_ack_n low.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  2  00 word, 01 half, 1x byte.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ack_n low.
- d_ack_n  out  1  data done, active-low, one-cycle pulse.
- bus_err  out  1  one-cycle pulse coincident with the ack of a timed-out access.
- m_req  out  1  memory request.
- m_write  out  1  memory write.
- m_size  out  2  memory size (00 for fetches).
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid with m_ack_n low.
- m_ack_n  in  1  memory done, active-low.

Behaviour:
- All outputs registered.
- Reset values:
  - i_ack_n = d_ack_n = 1; bus_err = 0.
  - m_req = m_write = 0; m_size = 00; m_addr = m_wdata = 0.
  - i_rdata = d_rdata = 0.
  - State IDLE; d_streak = 0; timer = 0.
- States IDLE → BUSY → RESP → IDLE.
- IDLE:
  - If neither request is present, stay.
  - Otherwise choose the owner:
    - only d_req → D;
    - only i_req → I;
    - both, d_streak < MAX_D_STREAK → D;
    - both, d_streak == MAX_D_STREAK → I.
  - Latch the owner's addr/size/write/wdata into m_* (fetch: m_write = 0, m_size = 00). Assert m_req next edge, timer = 0, go BUSY.
  - d_streak update:
    - D granted while i_req high → d_streak + 1, saturating at MAX_D_STREAK;
    - D granted with i_req low → d_streak = 0;
    - I granted → d_streak = 0.
- BUSY:
  - m_* held stable; requester inputs ignored.
  - m_ack_n == 0: capture m_rdata into the owner's rdata (write accesses capture too; value is don't-care). Drop m_req. Pulse owner ack_n = 0 next cycle. Go RESP.
  - Else timer + 1. Timer reaching TIMEOUT: drop m_req, owner rdata = 0, pulse owner ack_n = 0 and bus_err = 1, go RESP.
- RESP:
  - Ack (and bus_err) low/high for exactly this cycle.
  - Requests are not sampled; requester deasserts or presents the next request.
  - Next state IDLE.
- Latency: request seen in IDLE at cycle 0 → m_req at cycle 1 → memory ack at cycle 1+L−1 → requester ack one cycle later. With L = 1, ack at cycle 2 and back-to-back throughput is one access per 3 cycles.
- Only one owner at a time. A non-owner request stays pending without loss; its ack_n remains 1.
- m_ack_n is ignored outside BUSY.
- A request deasserted before ack in BUSY is a protocol violation; the access completes anyway.
- rst asserted mid-access: next edge all outputs take reset values, the in-flight access is abandoned, and no ack is issued.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum {IDLE, BUSY, RESP};
  - owner enum {OWN_I, OWN_D};
  - size constants SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10.
- One sub-module, arb_watchdog: the timer with start/clear/expired, parameterised by TIMEOUT.
- Grant logic and FSM stay in the top module.

Test Plan:
- Reset, then i_req with i_addr = 0x0000_0010; memory acks 1 cycle after m_req with 0x00A0_0093 → m_addr = 0x10, m_size = 00, i_rdata = 0x00A0_0093, i_ack_n low exactly 1 cycle, 2 cycles after request.
- Single d_req store, d_addr = 0x0800_0004, d_size = 10, d_wdata = 0x41 → m_write = 1, m_size = 10, m_wdata = 0x41; d_ack_n pulses; i_ack_n stays 1.
- Both requests held continuously, MAX_D_STREAK = 4 → grant order D, D, D, D, I, D, D, D, D, I.
- d_req load, memory never acks, TIMEOUT = 8 → m_req drops after 8 BUSY cycles; d_ack_n = 0, bus_err = 1, d_rdata = 0 for one cycle; then IDLE.
- rst pulsed in BUSY, 1 cycle after m_req → next edge m_req = 0, all acks 1, state IDLE; a later m_ack_n pulse causes no ack.
- Memory latency 3 with i_req held → m_addr/m_size stable for all 3 BUSY cycles; i_ack_n pulse 4 cycles after request; i_rdata matches memory data.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the unified memory port arbiter.
// States, bus owner and access size encodings.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts unacknowledged BUSY cycles and
// flags the cycle on which the access must be aborted.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // The TIMEOUT-th waiting cycle is the one that expires.
  assign expired = tick && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one memory port, data-first with
// a bounded fetch starvation window and an access watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack_n,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack_n,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_write,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack_n
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t state_q, state_d;
  owner_t own_q, own_d;
  logic [SW-1:0] streak_q, streak_d;

  logic              m_req_d, m_write_d;
  logic [1:0]        m_size_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_wdata_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;
  logic              i_ack_d, d_ack_d, err_d;

  logic wd_expired;
  logic d_wins, i_wins;
  logic done, abort;
  logic [DATA_W-1:0] rsp_data;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .tick   ((state_q == BUSY) && m_ack_n),
    .expired(wd_expired)
  );

  // Fetch wins a contested slot only once the streak is spent.
  assign d_wins = d_req && (!i_req || (streak_q < STREAK_MAX));
  assign i_wins = i_req && !d_wins;

  assign done     = (state_q == BUSY) && !m_ack_n;
  assign abort    = (state_q == BUSY) && m_ack_n && wd_expired;
  assign rsp_data = done ? m_rdata : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_req || d_req) state_d = BUSY;
      BUSY: if (done || abort) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d     = own_q;
    streak_d  = streak_q;
    m_req_d   = m_req;
    m_write_d = m_write;
    m_size_d  = m_size;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    i_ack_d   = 1'b1;
    d_ack_d   = 1'b1;
    err_d     = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        d_wins: begin
          own_d     = OWN_D;
          m_req_d   = 1'b1;
          m_write_d = d_write;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req) begin
            streak_d = '0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end
        i_wins: begin
          own_d     = OWN_I;
          m_req_d   = 1'b1;
          m_write_d = 1'b0;
          m_size_d  = SZ_WORD;
          m_addr_d  = i_addr;
          streak_d  = '0;
        end
        default: ;
      endcase
    end
    if (done || abort) begin
      m_req_d = 1'b0;
      err_d   = abort;
      if (own_q == OWN_D) begin
        d_rdata_d = rsp_data;
        d_ack_d   = 1'b0;
      end else begin
        i_rdata_d = rsp_data;
        i_ack_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      own_q    <= OWN_I;
      streak_q <= '0;
      m_req    <= 1'b0;
      m_write  <= 1'b0;
      m_size   <= SZ_WORD;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_ack_n  <= 1'b1;
      d_ack_n  <= 1'b1;
      bus_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      streak_q <= streak_d;
      m_req    <= m_req_d;
      m_write  <= m_write_d;
      m_size   <= m_size_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      i_rdata  <= i_rdata_d;
      d_rdata  <= d_rdata_d;
      i_ack_n  <= i_ack_d;
      d_ack_n  <= d_ack_d;
      bus_err  <= err_d;
    end
  end

endmodule
